id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 42 ++++
 rtl/id_ex_stage_if.sv | 70 +++++++
 rtl/id_ex_stage_fwd_mux.sv | 35 +++
 rtl/id_ex_stage.sv | 124 ++++++++++++
 tb/tb_id_ex_stage.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg
// Shared ALU operation codes and forwarding-select codes for the ID/EX stage,
// plus the helper that picks a forwarding source for one register operand.
package id_ex_stage_pkg;

    // ALU operation codes. They pass through the stage unchanged.
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;
    localparam logic [3:0] ALU_LUI = 4'h5;
    localparam logic [3:0] ALU_SLL = 4'h6;
    localparam logic [3:0] ALU_SRL = 4'h7;
    localparam logic [3:0] ALU_SRA = 4'h8;

    // Forwarding source select for one operand.
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,   // registered register-file value
        FWD_EXM = 2'd1,   // EX/MEM ALU result
        FWD_MWB = 2'd2    // MEM/WB write-back data
    } fwd_sel_e;

    // EX/MEM takes priority because it holds the younger result. $0 is never forwarded.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] reg_addr,
        input logic       exm_wreg,
        input logic [4:0] exm_waddr,
        input logic       mwb_wreg,
        input logic [4:0] mwb_waddr
    );
        if (reg_addr == 5'd0) begin
            return FWD_REG;
        end else if (exm_wreg && (exm_waddr == reg_addr)) begin
            return FWD_EXM;
        end else if (mwb_wreg && (mwb_waddr == reg_addr)) begin
            return FWD_MWB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if
// Bundle between the decode side and the ID/EX stage.
//   control    : i_hold, i_flush
//   ID side    : i_id_* decoded instruction fields and register-file operands
//   forwarding : i_exm_* (EX/MEM result), i_mwb_* (MEM/WB result)
//   EX side    : o_r, o_s, o_aluc (ALU operands/op), o_ex_* (downstream controls),
//                o_load_use (stall request to PC and IF/ID)
// master: decode/pipeline control side. slave: the stage itself.
interface id_ex_stage_if #(
    parameter int DATA_W = 32
);
    logic              i_hold;
    logic              i_flush;

    logic              i_id_valid;
    logic [DATA_W-1:0] i_id_rs_data;
    logic [DATA_W-1:0] i_id_rt_data;
    logic [DATA_W-1:0] i_id_imm;
    logic [4:0]        i_id_shamt;
    logic [4:0]        i_id_rs_addr;
    logic [4:0]        i_id_rt_addr;
    logic              i_id_use_rs;
    logic              i_id_use_rt;
    logic [4:0]        i_id_waddr;
    logic [3:0]        i_id_aluc;
    logic              i_id_aluimm;
    logic              i_id_shift;
    logic              i_id_wreg;
    logic              i_id_m2reg;
    logic              i_id_wmem;

    logic              i_exm_wreg;
    logic [4:0]        i_exm_waddr;
    logic [DATA_W-1:0] i_exm_alu;
    logic              i_mwb_wreg;
    logic [4:0]        i_mwb_waddr;
    logic [DATA_W-1:0] i_mwb_data;

    logic [DATA_W-1:0] o_r;
    logic [DATA_W-1:0] o_s;
    logic [3:0]        o_aluc;
    logic              o_ex_valid;
    logic              o_ex_wreg;
    logic [4:0]        o_ex_waddr;
    logic              o_ex_m2reg;
    logic              o_ex_wmem;
    logic [DATA_W-1:0] o_ex_store_data;
    logic              o_load_use;

    modport master (
        output i_hold, i_flush,
        output i_id_valid, i_id_rs_data, i_id_rt_data, i_id_imm, i_id_shamt,
        output i_id_rs_addr, i_id_rt_addr, i_id_use_rs, i_id_use_rt, i_id_waddr,
        output i_id_aluc, i_id_aluimm, i_id_shift, i_id_wreg, i_id_m2reg, i_id_wmem,
        output i_exm_wreg, i_exm_waddr, i_exm_alu, i_mwb_wreg, i_mwb_waddr, i_mwb_data,
        input  o_r, o_s, o_aluc, o_ex_valid, o_ex_wreg, o_ex_waddr, o_ex_m2reg,
        input  o_ex_wmem, o_ex_store_data, o_load_use
    );

    modport slave (
        input  i_hold, i_flush,
        input  i_id_valid, i_id_rs_data, i_id_rt_data, i_id_imm, i_id_shamt,
        input  i_id_rs_addr, i_id_rt_addr, i_id_use_rs, i_id_use_rt, i_id_waddr,
        input  i_id_aluc, i_id_aluimm, i_id_shift, i_id_wreg, i_id_m2reg, i_id_wmem,
        input  i_exm_wreg, i_exm_waddr, i_exm_alu, i_mwb_wreg, i_mwb_waddr, i_mwb_data,
        output o_r, o_s, o_aluc, o_ex_valid, o_ex_wreg, o_ex_waddr, o_ex_m2reg,
        output o_ex_wmem, o_ex_store_data, o_load_use
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux
// Forwarding compare/select for one register operand.
//   reg_addr, reg_data           : registered source register and its file value
//   exm_wreg/exm_waddr/exm_data  : EX/MEM forwarding source
//   mwb_wreg/mwb_waddr/mwb_data  : MEM/WB forwarding source
//   fwd_data                     : resolved operand value
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [4:0]        reg_addr,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              exm_wreg,
    input  logic [4:0]        exm_waddr,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              mwb_wreg,
    input  logic [4:0]        mwb_waddr,
    input  logic [DATA_W-1:0] mwb_data,
    output logic [DATA_W-1:0] fwd_data
);

    fwd_sel_e sel;

    always_comb begin
        sel = fwd_select(reg_addr, exm_wreg, exm_waddr, mwb_wreg, mwb_waddr);
        fwd_data = reg_data;
        case (sel)
            FWD_EXM: fwd_data = exm_data;
            FWD_MWB: fwd_data = mwb_data;
            default: fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register with operand forwarding and load-use detection.
//   i_clk  : clock, rising edge
//   i_rstn : asynchronous active-low reset; the stage holds a bubble while low
//   bus    : id_ex_stage_if slave port (hold/flush, ID fields, forwarding
//            sources, ALU operands, downstream controls, load-use stall)
// Load priority per edge: hold (keep) > flush (bubble) > load-use (bubble) > load.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    id_ex_stage_if.slave  bus
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        shamt;
        logic [4:0]        rs_addr;
        logic [4:0]        rt_addr;
        logic [4:0]        waddr;
        logic [3:0]        aluc;
        logic              aluimm;
        logic              shift;
        logic              wreg;
        logic              m2reg;
        logic              wmem;
    } ex_reg_t;

    ex_reg_t ex_q, ex_d, ex_load, ex_bubble;
    logic    load_use;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;

    // A load in EX whose destination the ID instruction reads cannot be forwarded in time.
    always_comb begin
        load_use = 1'b0;
        if (!bus.i_hold && ex_q.valid && ex_q.m2reg && (ex_q.waddr != 5'd0) && bus.i_id_valid) begin
            load_use = (bus.i_id_use_rs && (bus.i_id_rs_addr == ex_q.waddr)) ||
                       (bus.i_id_use_rt && (bus.i_id_rt_addr == ex_q.waddr));
        end
    end

    always_comb begin
        ex_load         = '0;
        ex_load.valid   = bus.i_id_valid;
        ex_load.rs_data = bus.i_id_rs_data;
        ex_load.rt_data = bus.i_id_rt_data;
        ex_load.imm     = bus.i_id_imm;
        ex_load.shamt   = bus.i_id_shamt;
        ex_load.rs_addr = bus.i_id_rs_addr;
        ex_load.rt_addr = bus.i_id_rt_addr;
        ex_load.waddr   = bus.i_id_waddr;
        ex_load.aluc    = bus.i_id_aluc;
        ex_load.aluimm  = bus.i_id_aluimm;
        ex_load.shift   = bus.i_id_shift;
        ex_load.wreg    = bus.i_id_wreg;
        ex_load.m2reg   = bus.i_id_m2reg;
        ex_load.wmem    = bus.i_id_wmem;

        ex_bubble      = '0;
        ex_bubble.aluc = ALU_ADD;

        if (bus.i_hold) begin
            ex_d = ex_q;
        end else if (bus.i_flush || load_use) begin
            ex_d = ex_bubble;
        end else begin
            ex_d = ex_load;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ex_q      <= '0;
            ex_q.aluc <= ALU_ADD;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Forwarding stays combinational so a held instruction keeps seeing fresh results.
    fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs (
        .reg_addr  (ex_q.rs_addr),
        .reg_data  (ex_q.rs_data),
        .exm_wreg  (bus.i_exm_wreg),
        .exm_waddr (bus.i_exm_waddr),
        .exm_data  (bus.i_exm_alu),
        .mwb_wreg  (bus.i_mwb_wreg),
        .mwb_waddr (bus.i_mwb_waddr),
        .mwb_data  (bus.i_mwb_data),
        .fwd_data  (rs_fwd)
    );

    fwd_mux #(.DATA_W(DATA_W)) u_fwd_rt (
        .reg_addr  (ex_q.rt_addr),
        .reg_data  (ex_q.rt_data),
        .exm_wreg  (bus.i_exm_wreg),
        .exm_waddr (bus.i_exm_waddr),
        .exm_data  (bus.i_exm_alu),
        .mwb_wreg  (bus.i_mwb_wreg),
        .mwb_waddr (bus.i_mwb_waddr),
        .mwb_data  (bus.i_mwb_data),
        .fwd_data  (rt_fwd)
    );

    always_comb begin
        bus.o_r             = ex_q.shift  ? {{(DATA_W-5){1'b0}}, ex_q.shamt} : rs_fwd;
        bus.o_s             = ex_q.aluimm ? ex_q.imm : rt_fwd;
        bus.o_aluc          = ex_q.aluc;
        bus.o_ex_valid      = ex_q.valid;
        bus.o_ex_wreg       = ex_q.wreg;
        bus.o_ex_waddr      = ex_q.waddr;
        bus.o_ex_m2reg      = ex_q.m2reg;
        bus.o_ex_wmem       = ex_q.wmem;
        bus.o_ex_store_data = rt_fwd;
        bus.o_load_use      = load_use;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk;
    logic rstn;
    int   n_total = 0;
    int   n_bad   = 0;

    id_ex_stage_if #(.DATA_W(32)) bus ();

    id_ex_stage #(.DATA_W(32)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_clear();
        bus.i_id_valid   = 1'b0;
        bus.i_id_rs_data = '0;
        bus.i_id_rt_data = '0;
        bus.i_id_imm     = '0;
        bus.i_id_shamt   = '0;
        bus.i_id_rs_addr = '0;
        bus.i_id_rt_addr = '0;
        bus.i_id_use_rs  = 1'b0;
        bus.i_id_use_rt  = 1'b0;
        bus.i_id_waddr   = '0;
        bus.i_id_aluc    = ALU_ADD;
        bus.i_id_aluimm  = 1'b0;
        bus.i_id_shift   = 1'b0;
        bus.i_id_wreg    = 1'b0;
        bus.i_id_m2reg   = 1'b0;
        bus.i_id_wmem    = 1'b0;
    endtask

    task automatic fwd_clear();
        bus.i_exm_wreg  = 1'b0;
        bus.i_exm_waddr = '0;
        bus.i_exm_alu   = '0;
        bus.i_mwb_wreg  = 1'b0;
        bus.i_mwb_waddr = '0;
        bus.i_mwb_data  = '0;
    endtask

    // Decoded R-type style instruction reading rs/rt and writing waddr.
    task automatic id_rtype(input logic [4:0] rs, input logic [31:0] rs_d, input logic [4:0] rt,
                            input logic [31:0] rt_d, input logic [4:0] wd, input logic [3:0] op);
        id_clear();
        bus.i_id_valid   = 1'b1;
        bus.i_id_rs_addr = rs;
        bus.i_id_rs_data = rs_d;
        bus.i_id_rt_addr = rt;
        bus.i_id_rt_data = rt_d;
        bus.i_id_use_rs  = 1'b1;
        bus.i_id_use_rt  = 1'b1;
        bus.i_id_waddr   = wd;
        bus.i_id_aluc    = op;
        bus.i_id_wreg    = 1'b1;
    endtask

    initial begin
        rstn        = 1'b0;
        bus.i_hold  = 1'b0;
        bus.i_flush = 1'b0;
        id_clear();
        fwd_clear();
        step();
        step();

        // Reset state
        check("rst_valid", 32'(bus.o_ex_valid), 32'd0);
        check("rst_wreg", 32'(bus.o_ex_wreg), 32'd0);
        check("rst_m2reg", 32'(bus.o_ex_m2reg), 32'd0);
        check("rst_wmem", 32'(bus.o_ex_wmem), 32'd0);
        check("rst_aluc", 32'(bus.o_aluc), 32'(ALU_ADD));
        check("rst_r", bus.o_r, 32'd0);
        check("rst_s", bus.o_s, 32'd0);
        check("rst_load_use", 32'(bus.o_load_use), 32'd0);
        rstn = 1'b1;

        // ADD $4,$3,$5 with $3 produced by the instruction now in EX/MEM
        id_rtype(5'd3, 32'h999, 5'd5, 32'h55, 5'd4, ALU_ADD);
        step();
        bus.i_exm_wreg  = 1'b1;
        bus.i_exm_waddr = 5'd3;
        bus.i_exm_alu   = 32'h10;
        #1;
        check("exm_fwd_r", bus.o_r, 32'h10);
        check("exm_fwd_s", bus.o_s, 32'h55);
        check("add_aluc", 32'(bus.o_aluc), 32'(ALU_ADD));
        check("add_valid", 32'(bus.o_ex_valid), 32'd1);
        check("add_waddr", 32'(bus.o_ex_waddr), 32'd4);
        check("add_wreg", 32'(bus.o_ex_wreg), 32'd1);
        fwd_clear();
        bus.i_mwb_wreg  = 1'b1;
        bus.i_mwb_waddr = 5'd5;
        bus.i_mwb_data  = 32'h77;
        #1;
        check("mwb_fwd_s", bus.o_s, 32'h77);
        check("mwb_no_r", bus.o_r, 32'h999);
        fwd_clear();

        // Both sources write $7: EX/MEM wins; then MEM/WB alone
        id_rtype(5'd1, 32'h11, 5'd7, 32'h1, 5'd9, ALU_OR);
        step();
        bus.i_exm_wreg  = 1'b1;
        bus.i_exm_waddr = 5'd7;
        bus.i_exm_alu   = 32'hAA;
        bus.i_mwb_wreg  = 1'b1;
        bus.i_mwb_waddr = 5'd7;
        bus.i_mwb_data  = 32'hBB;
        #1;
        check("both_s", bus.o_s, 32'hAA);
        check("both_store", bus.o_ex_store_data, 32'hAA);
        check("or_aluc", 32'(bus.o_aluc), 32'(ALU_OR));
        bus.i_exm_wreg = 1'b0;
        #1;
        check("mwb_only_s", bus.o_s, 32'hBB);

        // $0 is never forwarded
        id_rtype(5'd0, 32'h0, 5'd0, 32'h0, 5'd9, ALU_ADD);
        step();
        bus.i_exm_wreg  = 1'b1;
        bus.i_exm_waddr = 5'd0;
        bus.i_exm_alu   = 32'h55;
        bus.i_mwb_wreg  = 1'b1;
        bus.i_mwb_waddr = 5'd0;
        bus.i_mwb_data  = 32'h55;
        #1;
        check("zero_s", bus.o_s, 32'h0);
        check("zero_r", bus.o_r, 32'h0);
        fwd_clear();

        // LW $8 in EX, ADD reads $8 as rt
        id_clear();
        bus.i_id_valid   = 1'b1;
        bus.i_id_rs_addr = 5'd1;
        bus.i_id_rs_data = 32'h100;
        bus.i_id_use_rs  = 1'b1;
        bus.i_id_imm     = 32'h4;
        bus.i_id_aluimm  = 1'b1;
        bus.i_id_waddr   = 5'd8;
        bus.i_id_wreg    = 1'b1;
        bus.i_id_m2reg   = 1'b1;
        step();
        id_rtype(5'd1, 32'h1, 5'd8, 32'h2, 5'd10, ALU_ADD);
        bus.i_id_use_rt = 1'b0;
        #1;
        check("lu_not_used", 32'(bus.o_load_use), 32'd0);
        bus.i_id_use_rt = 1'b1;
        #1;
        check("lu_assert", 32'(bus.o_load_use), 32'd1);
        step();
        check("lu_bubble_valid", 32'(bus.o_ex_valid), 32'd0);
        check("lu_bubble_wreg", 32'(bus.o_ex_wreg), 32'd0);
        check("lu_bubble_aluc", 32'(bus.o_aluc), 32'(ALU_ADD));
        check("lu_after", 32'(bus.o_load_use), 32'd0);

        // SLL $2,$3,4 with $3 forwarded from EX/MEM
        id_rtype(5'd0, 32'h0, 5'd3, 32'h1234, 5'd2, ALU_SLL);
        bus.i_id_use_rs = 1'b0;
        bus.i_id_shift  = 1'b1;
        bus.i_id_shamt  = 5'd4;
        step();
        bus.i_exm_wreg  = 1'b1;
        bus.i_exm_waddr = 5'd3;
        bus.i_exm_alu   = 32'h3333;
        #1;
        check("sll_r", bus.o_r, 32'h4);
        check("sll_s", bus.o_s, 32'h3333);
        check("sll_aluc", 32'(bus.o_aluc), 32'(ALU_SLL));
        fwd_clear();

        // ADDI with all-ones immediate; store data still follows rt
        id_rtype(5'd2, 32'h20, 5'd9, 32'h5A5A, 5'd9, ALU_ADD);
        bus.i_id_aluimm = 1'b1;
        bus.i_id_imm    = 32'hFFFF_FFFF;
        step();
        check("addi_s", bus.o_s, 32'hFFFF_FFFF);
        check("addi_store", bus.o_ex_store_data, 32'h5A5A);
        check("addi_r", bus.o_r, 32'h20);

        // Hold beats flush and load-use; forwarding stays live during hold
        id_clear();
        bus.i_id_valid   = 1'b1;
        bus.i_id_rs_addr = 5'd1;
        bus.i_id_rs_data = 32'h100;
        bus.i_id_use_rs  = 1'b1;
        bus.i_id_aluimm  = 1'b1;
        bus.i_id_imm     = 32'h8;
        bus.i_id_waddr   = 5'd8;
        bus.i_id_wreg    = 1'b1;
        bus.i_id_m2reg   = 1'b1;
        step();
        id_rtype(5'd8, 32'h0, 5'd2, 32'h0, 5'd11, ALU_ADD);
        bus.i_hold  = 1'b1;
        bus.i_flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.i_exm_wreg  = 1'b1;
            bus.i_exm_waddr = 5'd1;
            bus.i_exm_alu   = 32'hCAFE_0000 + 32'(i);
            #1;
            check("hold_load_use", 32'(bus.o_load_use), 32'd0);
            check("hold_fwd_r", bus.o_r, 32'hCAFE_0000 + 32'(i));
            step();
            check("hold_valid", 32'(bus.o_ex_valid), 32'd1);
            check("hold_waddr", 32'(bus.o_ex_waddr), 32'd8);
            check("hold_m2reg", 32'(bus.o_ex_m2reg), 32'd1);
            check("hold_imm", bus.o_s, 32'h8);
        end
        fwd_clear();
        bus.i_hold = 1'b0;
        step();
        check("flush_valid", 32'(bus.o_ex_valid), 32'd0);
        check("flush_wreg", 32'(bus.o_ex_wreg), 32'd0);
        check("flush_m2reg", 32'(bus.o_ex_m2reg), 32'd0);
        check("flush_r", bus.o_r, 32'h0);
        check("flush_s", bus.o_s, 32'h0);
        bus.i_flush = 1'b0;

        // Asynchronous reset between edges discards the held instruction
        id_rtype(5'd4, 32'h44, 5'd5, 32'h66, 5'd12, ALU_SUB);
        bus.i_id_wmem = 1'b1;
        step();
        check("pre_rst_valid", 32'(bus.o_ex_valid), 32'd1);
        check("pre_rst_r", bus.o_r, 32'h44);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_valid", 32'(bus.o_ex_valid), 32'd0);
        check("arst_wreg", 32'(bus.o_ex_wreg), 32'd0);
        check("arst_wmem", 32'(bus.o_ex_wmem), 32'd0);
        check("arst_aluc", 32'(bus.o_aluc), 32'(ALU_ADD));
        check("arst_r", bus.o_r, 32'h0);
        rstn = 1'b1;
        step();
        check("post_rst_valid", 32'(bus.o_ex_valid), 32'd1);
        check("post_rst_aluc", 32'(bus.o_aluc), 32'(ALU_SUB));
        check("post_rst_wmem", 32'(bus.o_ex_wmem), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
